uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-byte FIFO placed directly downstream of the UART receiver (`uart_mux`) and upstream of the MCU's memory-mapped UART data register. It decouples byte arrival from CPU polling or interrupt latency. Every byte that `uart_mux` flags with `rx_full` is pushed; each CPU read of the UART data register pops one byte. It provides occupancy, full/empty and sticky-overrun status, plus a threshold interrupt level.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `WIDTH`, 8, entry width in bits
- `THRESH`, 1, `irq` asserts when `count` ≥ `THRESH`; legal range 1..`DEPTH`
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `clr`  in  1  synchronous flush: empties the FIFO and clears `overrun`
- `wr_en`  in  1  push `wr_data` this cycle (driven by `uart_mux` `rx_full`)
- `wr_data`  in  `WIDTH`  byte to push
- `rd_en`  in  1  pop head this cycle (CPU read of the UART data register)
- `rd_data`  out  `WIDTH`  head entry, first-word-fall-through; 0 while `empty`
- `empty`  out  1  no entries
- `full`  out  1  `count` == `DEPTH`
- `count`  out  $clog2(`DEPTH`)+1  current occupancy
- `overrun`  out  1  sticky; set when a push is dropped
- `ovr_clr`  in  1  clears `overrun`
- `irq`  out  1  `count` ≥ `THRESH` (level)

## Operation
- Pointers `wp` and `rp` are each $clog2(`DEPTH`)+1 bits wide. The index is the low bits; the MSB is a wrap flag.
  - `empty` = (`wp` == `rp`).
  - `full` = index bits equal and MSBs differ.
  - `count` = `wp` − `rp`, computed modulo 2^(log2 `DEPTH`+1).
- Push accepted = `wr_en` & (~`full` | `rd_en`). Writes `wr_data` to `mem[wp idx]`, then `wp`++.
- Pop accepted = `rd_en` & ~`empty`. `rp`++. A pop on empty is ignored: no state change, no error flag.
- Push while `full` without `rd_en`: byte is dropped, `overrun` ← 1, FIFO contents unchanged.
- `rd_en` & `wr_en` while `full`: both are accepted; `count` stays at `DEPTH`; no overrun.
- `rd_en` & `wr_en` while `empty`: push accepted, pop ignored (no bypass); `count` becomes 1.
- `overrun` update precedence: `clr` > `ovr_clr` > set-on-drop. If `ovr_clr` and a dropped push occur in the same cycle, `overrun` = 0.
- `clr` has priority over `wr_en`/`rd_en`. On `clr`: `wp` = `rp` = 0, `overrun` = 0, and that cycle's push is discarded.
- The storage array has no reset. Only pointers and flags reset.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `overrun`=0, `irq`=0, `rd_data`=0. `rst_n` low mid-stream discards all contents immediately, asynchronously.
- Push latency: push at edge N gives `empty`=0, `count`+1 and valid `rd_data` after edge N (visible in cycle N+1).
- Pop: after the `rd_en` edge, `rd_data` shows the next entry in the following cycle.
  - The CPU samples `rd_data` in the same cycle it asserts `rd_en`.
  - `rd_data` is combinational from `mem[rp idx]`, gated by `empty`.
- `irq`, `full`, `empty`, `count` are decoded from registered pointers: glitch-free, no combinational path from `wr_en`/`rd_en`.
- Pointer wrap: index wraps `DEPTH`−1 → 0 and toggles the MSB. Behaviour is identical across any number of wraps.

## Structure
- No shared typedefs.
- The register addresses used by the MCU (data 0x006, status 0x008) stay as `ADDR_WIDTH`-sized constants in `common.sv`. The FIFO itself is address-agnostic.
- One natural sub-module: `fifo_ram`, a `DEPTH`×`WIDTH` array with synchronous write and asynchronous read. It is kept separate so it can later map to distributed RAM. Pointer and flag logic stay in `uart_rx_fifo`.

## Test plan
Bench uses `DEPTH`=4, `THRESH`=2.
- Reset, then push 0x41, 0x42 on consecutive cycles → next cycle `count`=2, `irq`=1, `rd_data`=0x41. Pop → `rd_data`=0x42, `count`=1, `irq`=0.
- Push 0x10..0x13 → `full`=1. Push 0x14 → `overrun`=1, contents unchanged. Pop ×4 → reads 0x10..0x13, then `empty`=1, `rd_data`=0.
- While full, assert `rd_en` and `wr_en`(0x55) together → `count` stays 4, no overrun. Draining yields 0x11, 0x12, 0x13, 0x55.
- Run 10 push/pop pairs (0x00..0x09) to force pointer wrap → every pop matches its push, `count` never exceeds 1, `full` is never asserted.
- With `count`=3 and `overrun`=1, assert `clr` with `wr_en` → next cycle `empty`=1, `count`=0, `overrun`=0. Pop on empty → no change.
- Drive `rst_n` low asynchronously mid-cycle with 2 entries stored → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Purpose : default geometry for the UART receive FIFO and its storage array.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

  // Default geometry: one UART byte per entry, sixteen entries deep.
  localparam int unsigned RXF_DEPTH_DEF  = 16;
  localparam int unsigned RXF_WIDTH_DEF  = 8;
  // Default interrupt threshold: raise irq as soon as one byte is waiting.
  localparam int unsigned RXF_THRESH_DEF = 1;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Purpose : DEPTH x WIDTH storage for the UART receive FIFO. Synchronous
//           write, asynchronous read, no reset on the array so it can map
//           onto distributed RAM.
// Ports   : clk    - system clock
//           we     - write enable
//           waddr  - write index
//           wdata  - write data
//           raddr  - read index
//           rdata  - combinational read data at raddr
// -----------------------------------------------------------------------------
module fifo_ram
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = RXF_DEPTH_DEF,
  parameter int unsigned WIDTH = RXF_WIDTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule : fifo_ram

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Purpose : receive-byte FIFO between the UART receiver and the CPU data
//           register. First-word-fall-through head, occupancy/full/empty
//           status, sticky overrun and a level threshold interrupt.
// Ports   : clk      - system clock
//           rst_n    - asynchronous active-low reset (pointers and flags)
//           clr      - synchronous flush, also clears overrun
//           wr_en    - push wr_data this cycle
//           wr_data  - byte to push
//           rd_en    - pop the head this cycle
//           rd_data  - head entry, zero while empty
//           empty    - no entries stored
//           full     - count equals DEPTH
//           count    - current occupancy
//           overrun  - sticky, set when a push is dropped
//           ovr_clr  - clears overrun
//           irq      - level, count >= THRESH
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = RXF_DEPTH_DEF,
  parameter int unsigned WIDTH  = RXF_WIDTH_DEF,
  parameter int unsigned THRESH = RXF_THRESH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] THRESH_P = PW'(THRESH);

  // Pointers carry one extra MSB as a wrap flag so full and empty differ.
  logic [PW-1:0]    wp_r;
  logic [PW-1:0]    rp_r;
  logic             overrun_r;

  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [WIDTH-1:0] ram_rdata_s;

  // Status is decoded only from registered pointers, so it never glitches
  // on wr_en/rd_en.
  assign empty = (wp_r == rp_r);
  assign full  = (wp_r[AW-1:0] == rp_r[AW-1:0]) && (wp_r[AW] != rp_r[AW]);
  assign count = wp_r - rp_r;
  assign irq   = (count >= THRESH_P);

  // A simultaneous pop frees the head slot, so a push while full is still
  // accepted when rd_en is high. The write lands on the slot being read,
  // which the CPU has already sampled combinationally this cycle.
  assign push_s = wr_en & (~full | rd_en) & ~clr;
  assign pop_s  = rd_en & ~empty & ~clr;
  assign drop_s = wr_en & full & ~rd_en & ~clr;

  assign overrun = overrun_r;
  assign rd_data = empty ? {WIDTH{1'b0}} : ram_rdata_s;

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_fifo_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wp_r[AW-1:0]),
    .wdata (wr_data),
    .raddr (rp_r[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // Write and read pointers; flush returns both to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r <= PTR_ZERO;
      rp_r <= PTR_ZERO;
    end else if (clr) begin
      wp_r <= PTR_ZERO;
      rp_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PTR_ONE;
      end
      if (pop_s) begin
        rp_r <= rp_r + PTR_ONE;
      end
    end
  end

  // Sticky overrun: flush beats explicit clear, explicit clear beats a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (clr) begin
      overrun_r <= 1'b0;
    end else if (ovr_clr) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end
  end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Purpose : self-checking bench for uart_rx_fifo with DEPTH=4, THRESH=2.
//           Directed vector table plus hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overrun;
  logic       ovr_clr;
  logic       irq;

  int checks;
  int errors;

  uart_rx_fifo #(
    .DEPTH  (4),
    .WIDTH  (8),
    .THRESH (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .ovr_clr (ovr_clr),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       cl;
    logic       oc;
    logic [2:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovr;
    logic       irq;
    logic [7:0] rdd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic [7:0] wd, input logic rd,
                     input logic cl, input logic oc, input logic [2:0] cnt,
                     input logic emp, input logic ful, input logic ovr,
                     input logic iq, input logic [7:0] rdd);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.cl = cl; v.oc = oc;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.ovr = ovr; v.irq = iq; v.rdd = rdd;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd,
                      input logic cl, input logic oc);
    wr_en = wr; wr_data = wd; rd_en = rd; clr = cl; ovr_clr = oc;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; ovr_clr = 1'b0;
  endtask

  // Compare the full status word against an expectation.
  task automatic check_all(input string name, input logic [2:0] cnt,
                           input logic emp, input logic ful, input logic ovr,
                           input logic iq, input logic [7:0] rdd);
    logic [14:0] act;
    logic [14:0] exp;
    act = {count, empty, full, overrun, irq, rd_data};
    exp = {cnt, emp, ful, ovr, iq, rdd};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%0d empty=%b full=%b overrun=%b irq=%b rd_data=%h, expected count=%0d empty=%b full=%b overrun=%b irq=%b rd_data=%h",
               name, count, empty, full, overrun, irq, rd_data,
               cnt, emp, ful, ovr, iq, rdd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    rd_en = 1'b0; ovr_clr = 1'b0;

    // Test scenario A: two pushes, one pop, then drain.
    add(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41);
    add(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    // Scenario B: fill, overrun drop, drain, clear overrun.
    add(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    add(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    add(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    add(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h13);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    // Scenario C: simultaneous push/pop while full, ovr_clr beats drop.
    add(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    add(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    add(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
    add(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    add(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
    add(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h13);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    // Pop on empty is ignored; push+pop on empty accepts only the push.
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset state while rst_n held low.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_release", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].cl, vecs[i].oc);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp,
                vecs[i].ful, vecs[i].ovr, vecs[i].irq, vecs[i].rdd);
    end

    // Pointer wrap: ten push/pop pairs through a 4-deep FIFO.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      check_all($sformatf("wrap_push%0d", i), 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check_all($sformatf("wrap_pop%0d", i), 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end

    // Flush with count=3, overrun=1 and a concurrent push.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_all("pre_clr", 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1);
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    check_all("clr", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_all("pop_after_clr", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check_all("push_after_clr", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with two entries stored.
    step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    check_all("pre_async", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    check_all("push_after_reset", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
